pipe_stage_skid: RTL and testbench



---
 rtl/pipe_stage_skid.sv | 85 ++++++++
 tb/tb_pipe_stage_skid.sv | 121 ++++++++++++
 2 files changed

// File: rtl/pipe_stage_skid.sv
// pipe_stage_skid: valid/ready pipeline register with 2-entry skid buffer, flush and saturating transfer count
module pipe_stage_skid #(
  parameter int                CNT_W           = 16,
  parameter int                DATA_W          = 16,
  parameter logic [DATA_W-1:0] BUBBLE_VAL      = '0,
  parameter bit                CLEAR_ON_BUBBLE = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  input  logic              flush,
  output logic              flush_drop,
  output logic [CNT_W-1:0]  xfer_count
);
  typedef enum logic [1:0] {EMPTY, ONE, FULL} state_t;
  state_t            state_q, state_d;
  logic [DATA_W-1:0] main_q, main_d, skid_q, skid_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              in_ready_q, flush_drop_q, flush_drop_d, in_fire, out_fire;
  assign in_ready   = in_ready_q;
  assign out_valid  = state_q != EMPTY;
  assign out_data   = main_q;
  assign flush_drop = flush_drop_q;
  assign xfer_count = cnt_q;
  always_comb begin
    in_fire      = in_valid & in_ready_q;
    out_fire     = out_valid & out_ready;
    state_d      = state_q;
    main_d       = main_q;
    skid_d       = skid_q;
    cnt_d        = (out_fire && cnt_q != '1) ? cnt_q + CNT_W'(1) : cnt_q;
    flush_drop_d = flush & (state_q == FULL | (state_q == ONE & ~out_fire));
    if (flush) begin
      state_d = EMPTY;
      if (CLEAR_ON_BUBBLE) begin
        main_d = BUBBLE_VAL;
        skid_d = BUBBLE_VAL;
      end
    end else begin
      case (state_q)
        EMPTY: if (in_fire) begin
          state_d = ONE;
          main_d  = in_data;
        end
        ONE: if (in_fire & out_fire) begin
          main_d = in_data;
        end else if (in_fire) begin
          state_d = FULL;
          skid_d  = in_data;
        end else if (out_fire) begin
          state_d = EMPTY;
          if (CLEAR_ON_BUBBLE) main_d = BUBBLE_VAL;
        end
        FULL: if (out_fire) begin
          state_d = ONE;
          main_d  = skid_q;
          if (CLEAR_ON_BUBBLE) skid_d = BUBBLE_VAL;
        end
        default: state_d = EMPTY;
      endcase
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= EMPTY;
      main_q       <= BUBBLE_VAL;
      skid_q       <= BUBBLE_VAL;
      in_ready_q   <= 1'b1;
      flush_drop_q <= 1'b0;
      cnt_q        <= '0;
    end else begin
      state_q      <= state_d;
      main_q       <= main_d;
      skid_q       <= skid_d;
      in_ready_q   <= state_d != FULL;
      flush_drop_q <= flush_drop_d;
      cnt_q        <= cnt_d;
    end
  end
endmodule

// File: tb/tb_pipe_stage_skid.sv
// tb_pipe_stage_skid: queue-model scoreboard for a default stage and a CNT_W=2 / no-clear stage
module tb_pipe_stage_skid;
  logic        clk = 1'b0, rst = 1'b1;
  logic        in_valid = 1'b0, out_ready = 1'b0, flush = 1'b0;
  logic [15:0] in_data = '0;
  logic        u_in_ready, u_out_valid, u_flush_drop;
  logic        p_in_ready, p_out_valid, p_flush_drop;
  logic [15:0] u_out_data, p_out_data, u_xfer_count;
  logic [1:0]  p_xfer_count;
  int          vectors = 0, errors = 0;
  logic [15:0] q[$];
  logic [15:0] m_last;
  logic        m_ready, m_drop, mv = 1'b0, acc = 1'b0, of, inf;
  int          m_cnt;
  always #5 clk = ~clk;
  pipe_stage_skid u_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(u_in_ready), .in_data(in_data),
    .out_valid(u_out_valid), .out_ready(out_ready), .out_data(u_out_data),
    .flush(flush), .flush_drop(u_flush_drop), .xfer_count(u_xfer_count)
  );
  pipe_stage_skid #(.CNT_W(2), .CLEAR_ON_BUBBLE(1'b0)) p_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(p_in_ready), .in_data(in_data),
    .out_valid(p_out_valid), .out_ready(out_ready), .out_data(p_out_data),
    .flush(flush), .flush_drop(p_flush_drop), .xfer_count(p_xfer_count)
  );
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask
  always @(negedge clk) begin
    if (mv) begin
      chk("u_out_valid", u_out_valid, q.size() != 0);
      chk("p_out_valid", p_out_valid, q.size() != 0);
      chk("u_in_ready", u_in_ready, m_ready);
      chk("p_in_ready", p_in_ready, m_ready);
      chk("u_flush_drop", u_flush_drop, m_drop);
      chk("p_flush_drop", p_flush_drop, m_drop);
      chk("u_xfer_count", u_xfer_count, m_cnt & 16'hFFFF);
      chk("p_xfer_count_sat", p_xfer_count, m_cnt > 3 ? 3 : m_cnt);
      if (q.size() != 0) begin
        chk(out_ready ? "u_data_pop" : "u_data_hold", u_out_data, q[0]);
        chk(out_ready ? "p_data_pop" : "p_data_hold", p_out_data, q[0]);
      end else begin
        chk("u_idle_bubble", u_out_data, 16'h0000);
        chk("p_idle_stale", p_out_data, m_last);
      end
    end
    if (rst) begin
      q.delete();
      m_ready = 1'b1;
      m_drop  = 1'b0;
      m_cnt   = 0;
      m_last  = 16'h0000;
      mv      = 1'b1;
    end else if (mv) begin
      of     = q.size() != 0 && out_ready;
      inf    = in_valid && m_ready;
      m_drop = flush && (q.size() == 2 || (q.size() == 1 && !of));
      if (of) m_cnt++;
      if (flush) q.delete();
      else begin
        if (of) void'(q.pop_front());
        if (inf) q.push_back(in_data);
      end
      if (q.size() != 0) m_last = q[0];
      m_ready = q.size() < 2;
    end
  end
  task automatic tick();
    @(negedge clk);
    acc = in_valid & u_in_ready;
    @(posedge clk);
    #1;
  endtask
  task automatic drv(input logic iv, input logic [15:0] d, input logic ordy, input logic fl);
    in_valid  = iv;
    in_data   = d;
    out_ready = ordy;
    flush     = fl;
    tick();
  endtask
  initial begin
    rst = 1'b1;
    drv(1'b1, 16'hBEEF, 1'b0, 1'b0);
    drv(1'b1, 16'hBEEF, 1'b0, 1'b0);
    rst = 1'b0;
    drv(1'b0, 16'h0000, 1'b1, 1'b0);
    for (int i = 1; i <= 8; i++) drv(1'b1, 16'(i), 1'b1, 1'b0);
    repeat (2) drv(1'b0, 16'h0000, 1'b1, 1'b0);
    drv(1'b1, 16'hA000, 1'b0, 1'b0);
    drv(1'b1, 16'hA001, 1'b0, 1'b0);
    repeat (2) drv(1'b0, 16'h0000, 1'b0, 1'b0);
    repeat (3) drv(1'b0, 16'h0000, 1'b1, 1'b0);
    drv(1'b1, 16'hA000, 1'b0, 1'b0);
    drv(1'b1, 16'hA001, 1'b0, 1'b0);
    drv(1'b1, 16'hC0DE, 1'b0, 1'b1);
    repeat (3) drv(1'b0, 16'h0000, 1'b1, 1'b0);
    drv(1'b1, 16'h0055, 1'b0, 1'b0);
    drv(1'b0, 16'h0000, 1'b1, 1'b1);
    repeat (2) drv(1'b0, 16'h0000, 1'b1, 1'b0);
    for (int i = 0; i < 800; i++) begin
      if (!in_valid || acc || flush || rst) begin
        in_valid = $urandom_range(0, 3) != 0;
        in_data  = 16'($urandom);
      end
      out_ready = $urandom_range(0, 3) != 0;
      flush     = $urandom_range(0, 19) == 0;
      rst       = $urandom_range(0, 149) == 0;
      tick();
    end
    rst = 1'b0;
    drv(1'b0, 16'h0000, 1'b1, 1'b0);
    @(negedge clk);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
